// File: rtl/m_w_reg_pkg.sv
// Shared constants and types for the M/W pipeline register: reset/bubble values
// and the Tnew encoding used by the W-stage hazard logic.
package m_w_reg_pkg;

    localparam int unsigned TNEW_W = 2;

    typedef logic [TNEW_W-1:0] tnew_t;

    localparam tnew_t TNEW_0 = 2'd0;
    localparam tnew_t TNEW_1 = 2'd1;
    localparam tnew_t TNEW_2 = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;

    // Writes to $0 are architecturally discarded, so they never reach the GRF.
    function automatic logic grf_write_en(input logic we, input logic valid, input logic [4:0] a3);
        return we & valid & (a3 != 5'd0);
    endfunction

endpackage

// File: rtl/m_w_reg_if.sv
// M-to-W stage bundle: M-side inputs, hazard controls and W-side registered outputs.
// The pipeline register itself uses the slave modport.
interface m_w_reg_if
    import m_w_reg_pkg::*;
#(
    parameter int unsigned DW = 32
);
    logic          Req;
    logic          stall;
    logic          flush;

    logic [31:0]   M_instr;
    logic [31:0]   M_pc;
    logic [DW-1:0] M_ALUout;
    logic [DW-1:0] M_DMout;
    logic [4:0]    M_A3;
    logic          M_RegWrite;
    tnew_t         M_Tnew;
    logic          M_valid;

    logic [31:0]   W_instr;
    logic [31:0]   W_pc;
    logic [DW-1:0] W_ALUout;
    logic [DW-1:0] W_DMout;
    logic [4:0]    W_A3;
    logic          W_RegWrite;
    tnew_t         W_Tnew;
    logic          W_valid;
    logic [31:0]   retire_cnt;

    modport master (
        output Req, stall, flush,
        output M_instr, M_pc, M_ALUout, M_DMout, M_A3, M_RegWrite, M_Tnew, M_valid,
        input  W_instr, W_pc, W_ALUout, W_DMout, W_A3, W_RegWrite, W_Tnew, W_valid,
        input  retire_cnt
    );

    modport slave (
        input  Req, stall, flush,
        input  M_instr, M_pc, M_ALUout, M_DMout, M_A3, M_RegWrite, M_Tnew, M_valid,
        output W_instr, W_pc, W_ALUout, W_DMout, W_A3, W_RegWrite, W_Tnew, W_valid,
        output retire_cnt
    );

endinterface

// File: rtl/m_w_reg_tnew_dec.sv
// Saturating Tnew decrement applied as an instruction advances one stage.
// Also reusable by the E/M register.
module m_w_reg_tnew_dec
    import m_w_reg_pkg::*;
(
    input  tnew_t i_tnew,
    output tnew_t o_tnew
);

    assign o_tnew = (i_tnew == TNEW_0) ? TNEW_0 : tnew_t'(i_tnew - TNEW_1);

endmodule

// File: rtl/m_w_reg.sv
// M/W pipeline register of the P7 MIPS core with stall, flush and CP0-request
// bubbles, plus a retired-instruction counter.
module m_w_reg
    import m_w_reg_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    m_w_reg_if.slave    bus
);

    logic [31:0]   r_instr;
    logic [31:0]   r_pc;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_dm;
    logic [4:0]    r_a3;
    logic          r_regwrite;
    tnew_t         r_tnew;
    logic          r_valid;
    logic [31:0]   r_retire_cnt;

    logic          w_bubble;
    logic          w_load;
    logic          w_regwrite;
    tnew_t         w_tnew;

    assign w_bubble   = bus.Req | bus.flush;
    assign w_load     = ~reset & ~w_bubble & ~bus.stall;
    assign w_regwrite = grf_write_en(bus.M_RegWrite, bus.M_valid, bus.M_A3);

    m_w_reg_tnew_dec u_tnew_dec (
        .i_tnew (bus.M_Tnew),
        .o_tnew (w_tnew)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr      <= NOP_INSTR;
            r_pc         <= RESET_PC;
            r_alu        <= '0;
            r_dm         <= '0;
            r_a3         <= '0;
            r_regwrite   <= 1'b0;
            r_tnew       <= TNEW_0;
            r_valid      <= 1'b0;
            r_retire_cnt <= '0;
        end else if (w_bubble) begin
            // Bubble keeps the incoming PC so EPC bookkeeping stays monotonic.
            r_instr    <= NOP_INSTR;
            r_pc       <= bus.M_pc;
            r_alu      <= '0;
            r_dm       <= '0;
            r_a3       <= '0;
            r_regwrite <= 1'b0;
            r_tnew     <= TNEW_0;
            r_valid    <= 1'b0;
        end else if (!bus.stall) begin
            r_instr    <= bus.M_instr;
            r_pc       <= bus.M_pc;
            r_alu      <= bus.M_ALUout;
            r_dm       <= bus.M_DMout;
            r_a3       <= bus.M_A3;
            r_regwrite <= w_regwrite;
            r_tnew     <= w_tnew;
            r_valid    <= bus.M_valid;
            if (bus.M_valid) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign bus.W_instr    = r_instr;
    assign bus.W_pc       = r_pc;
    assign bus.W_ALUout   = r_alu;
    assign bus.W_DMout    = r_dm;
    assign bus.W_A3       = r_a3;
    assign bus.W_RegWrite = r_regwrite;
    assign bus.W_Tnew     = r_tnew;
    assign bus.W_valid    = r_valid;
    assign bus.retire_cnt = r_retire_cnt;

    // Tnew=2 cannot legally reach the M stage; catch upstream decode bugs early.
    a_tnew_legal: assert property (
        @(posedge clk) disable iff (reset)
        (w_load && bus.M_valid) |-> (bus.M_Tnew != TNEW_2)
    );

endmodule
